// File: rtl/des_pkg.sv
// ----------------------------------------------------------------------------
// des_pkg
//   Shared constants and types for the iterative DES round controller.
//   Contents:
//     DES_ROUNDS   - number of Feistel rounds (16)
//     DES_SUBKEY_W - width of one round subkey (48)
//     DES_BLOCK_W  - data block width handled by the round datapath (64)
//     DES_CNT_W    - width of the round counter / round index (4)
//     des_state_e  - controller FSM states {IDLE, RUN, DONE}
//     des_mode_e   - mode encoding (0 = encrypt, 1 = decrypt)
//     des_key_slot - maps a round number to the subkey slot used for it
// ----------------------------------------------------------------------------
package des_pkg;

    localparam int DES_ROUNDS   = 16;
    localparam int DES_SUBKEY_W = 48;
    localparam int DES_BLOCK_W  = 64;
    localparam int DES_CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } des_state_e;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } des_mode_e;

    // Decrypt walks the schedule backwards. The subtraction stays in
    // DES_CNT_W bits, so 15-idx can never underflow for a 4-bit idx.
    function automatic logic [DES_CNT_W-1:0] des_key_slot(
        input logic [DES_CNT_W-1:0] idx,
        input des_mode_e            mode
    );
        logic [DES_CNT_W-1:0] last;
        last = DES_CNT_W'(DES_ROUNDS - 1);
        return (mode == MODE_DEC) ? (last - idx) : idx;
    endfunction

endpackage

// File: rtl/des_subkey_select.sv
// ----------------------------------------------------------------------------
// des_subkey_select
//   Purely combinational subkey picker. Selects the subkey for the current
//   round out of a packed 16-entry bundle, forward for encrypt and reversed
//   for decrypt.
//   Ports:
//     keys_i   in  ROUNDS*SUBKEY_W  subkey k at [ROUNDS*SUBKEY_W-1-SUBKEY_W*k -: SUBKEY_W]
//     idx_i    in  4                current round index
//     mode_i   in  1                0 = encrypt, 1 = decrypt
//     subkey_o out SUBKEY_W         subkey for this round
// ----------------------------------------------------------------------------
module des_subkey_select
    import des_pkg::*;
#(
    parameter int ROUNDS   = DES_ROUNDS,
    parameter int SUBKEY_W = DES_SUBKEY_W
) (
    input  logic [ROUNDS*SUBKEY_W-1:0] keys_i,
    input  logic [DES_CNT_W-1:0]       idx_i,
    input  logic                       mode_i,
    output logic [SUBKEY_W-1:0]        subkey_o
);

    // Packed view of the bundle. Subkey 0 lives in the MSBs, so it lands in
    // element ROUNDS-1 of this array.
    logic [ROUNDS-1:0][SUBKEY_W-1:0] bank;
    logic [DES_CNT_W-1:0]            slot;

    assign bank     = keys_i;
    assign slot     = des_key_slot(idx_i, des_mode_e'(mode_i));
    assign subkey_o = bank[DES_CNT_W'(ROUNDS - 1) - slot];

endmodule

// File: rtl/des_round_sequencer.sv
// ----------------------------------------------------------------------------
// des_round_sequencer
//   Iterative DES round controller. Accepts one 16-subkey bundle and a mode,
//   then steps a shared single-round datapath for 16 consecutive cycles, one
//   subkey per cycle. Completion is reported with a valid/ready handshake.
//   Ports:
//     clk, rst          clock / synchronous active-high reset
//     start_valid/ready request handshake (ready is a Moore output)
//     encrypt_decrypt   0 = encrypt (forward keys), 1 = decrypt (reversed)
//     round_keys_i      subkey bundle, subkey 0 in the MSBs
//     rnd_load          first-round strobe for the datapath input load
//     rnd_en            datapath performs a round this cycle
//     rnd_idx           current round index 0..15
//     rnd_key           subkey for the current round
//     rnd_last          current round is the final one
//     done_valid/ready  completion handshake (valid is a Moore output)
//     busy              high in RUN or DONE
//   Every output is decoded from registers only; no input reaches an output
//   combinationally.
// ----------------------------------------------------------------------------
module des_round_sequencer
    import des_pkg::*;
#(
    parameter int ROUNDS   = DES_ROUNDS,
    parameter int SUBKEY_W = DES_SUBKEY_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic                       encrypt_decrypt,
    input  logic [ROUNDS*SUBKEY_W-1:0] round_keys_i,
    output logic                       rnd_load,
    output logic                       rnd_en,
    output logic [DES_CNT_W-1:0]       rnd_idx,
    output logic [SUBKEY_W-1:0]        rnd_key,
    output logic                       rnd_last,
    output logic                       done_valid,
    input  logic                       done_ready,
    output logic                       busy
);

    localparam logic [DES_CNT_W-1:0] LAST_IDX = DES_CNT_W'(ROUNDS - 1);
    localparam logic [DES_CNT_W-1:0] PENULT   = DES_CNT_W'(ROUNDS - 2);

    des_state_e                 state_q;
    logic [DES_CNT_W-1:0]       cnt_q;
    logic                       mode_q;
    logic [ROUNDS*SUBKEY_W-1:0] key_q;

    // Registered handshake / strobe flags, updated alongside the state.
    logic start_ready_q;
    logic done_valid_q;
    logic busy_q;
    logic rnd_en_q;
    logic rnd_load_q;
    logic rnd_last_q;

    logic [SUBKEY_W-1:0] sel_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mode_q        <= 1'b0;
            key_q         <= '0;
            start_ready_q <= 1'b1;
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            rnd_en_q      <= 1'b0;
            rnd_load_q    <= 1'b0;
            rnd_last_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // start_ready_q is 1 throughout IDLE, so valid alone
                    // completes the handshake here.
                    if (start_valid) begin
                        state_q       <= RUN;
                        key_q         <= round_keys_i;
                        mode_q        <= encrypt_decrypt;
                        cnt_q         <= '0;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        rnd_en_q      <= 1'b1;
                        rnd_load_q    <= 1'b1;
                        rnd_last_q    <= 1'b0;
                    end
                end
                RUN: begin
                    rnd_load_q <= 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        state_q      <= DONE;
                        cnt_q        <= '0;
                        rnd_en_q     <= 1'b0;
                        rnd_last_q   <= 1'b0;
                        done_valid_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q + 1'b1;
                        rnd_last_q <= (cnt_q == PENULT);
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        state_q       <= IDLE;
                        done_valid_q  <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    cnt_q         <= '0;
                    start_ready_q <= 1'b1;
                    done_valid_q  <= 1'b0;
                    busy_q        <= 1'b0;
                    rnd_en_q      <= 1'b0;
                    rnd_load_q    <= 1'b0;
                    rnd_last_q    <= 1'b0;
                end
            endcase
        end
    end

    des_subkey_select #(
        .ROUNDS   (ROUNDS),
        .SUBKEY_W (SUBKEY_W)
    ) u_sel (
        .keys_i   (key_q),
        .idx_i    (cnt_q),
        .mode_i   (mode_q),
        .subkey_o (sel_key)
    );

    // rnd_en_q is high exactly in RUN; gate the index and key with it so
    // the datapath sees zeros outside a run.
    assign start_ready = start_ready_q;
    assign done_valid  = done_valid_q;
    assign busy        = busy_q;
    assign rnd_en      = rnd_en_q;
    assign rnd_load    = rnd_load_q;
    assign rnd_last    = rnd_last_q;
    assign rnd_idx     = rnd_en_q ? cnt_q : '0;
    assign rnd_key     = rnd_en_q ? sel_key : '0;

endmodule

// File: tb/tb_des_round_sequencer.sv
module tb_des_round_sequencer;

    localparam int R = 16;
    localparam int W = 48;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_valid;
    logic           start_ready;
    logic           encrypt_decrypt;
    logic [R*W-1:0] round_keys_i;
    logic           rnd_load;
    logic           rnd_en;
    logic [3:0]     rnd_idx;
    logic [W-1:0]   rnd_key;
    logic           rnd_last;
    logic           done_valid;
    logic           done_ready;
    logic           busy;

    logic [R*W-1:0] bundle_a;
    logic [R*W-1:0] bundle_b;

    int pass_cnt = 0;
    int total    = 0;

    des_round_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start_valid     (start_valid),
        .start_ready     (start_ready),
        .encrypt_decrypt (encrypt_decrypt),
        .round_keys_i    (round_keys_i),
        .rnd_load        (rnd_load),
        .rnd_en          (rnd_en),
        .rnd_idx         (rnd_idx),
        .rnd_key         (rnd_key),
        .rnd_last        (rnd_last),
        .done_valid      (done_valid),
        .done_ready      (done_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Subkey k = {base+k, 40'h0}, subkey 0 in the MSBs.
    function automatic logic [R*W-1:0] make_bundle(input logic [7:0] base);
        logic [R*W-1:0] b;
        b = '0;
        for (int k = 0; k < R; k++)
            b[R*W-1-W*k -: W] = {base + 8'(k), 40'h0};
        return b;
    endfunction

    // Called in cycle T+1 after an accept; checks all rounds and the DONE cycle.
    task automatic run_rounds(input string name, input logic dec, input logic [7:0] base);
        logic [7:0] eb;
        for (int k = 0; k < R; k++) begin
            eb = dec ? (base + 8'(15 - k)) : (base + 8'(k));
            chk({name, "_en"},   64'(rnd_en),   64'(1));
            chk({name, "_idx"},  64'(rnd_idx),  64'(k));
            chk({name, "_key"},  64'(rnd_key),  64'({eb, 40'h0}));
            chk({name, "_load"}, 64'(rnd_load), 64'(k == 0));
            chk({name, "_last"}, 64'(rnd_last), 64'(k == 15));
            chk({name, "_dv"},   64'(done_valid), 64'(0));
            chk({name, "_sr"},   64'(start_ready), 64'(0));
            tick();
        end
        chk({name, "_done_dv"},  64'(done_valid), 64'(1));
        chk({name, "_done_en"},  64'(rnd_en),     64'(0));
        chk({name, "_done_key"}, 64'(rnd_key),    64'(0));
        chk({name, "_done_idx"}, 64'(rnd_idx),    64'(0));
        chk({name, "_done_bsy"}, 64'(busy),       64'(1));
    endtask

    initial begin
        bundle_a        = make_bundle(8'hA0);
        bundle_b        = make_bundle(8'hB0);
        rst             = 1'b1;
        start_valid     = 1'b0;
        done_ready      = 1'b0;
        encrypt_decrypt = 1'b0;
        round_keys_i    = '0;

        // Reset state
        tick(); tick();
        chk("rst_sr",   64'(start_ready), 64'(1));
        chk("rst_en",   64'(rnd_en),      64'(0));
        chk("rst_load", 64'(rnd_load),    64'(0));
        chk("rst_last", 64'(rnd_last),    64'(0));
        chk("rst_dv",   64'(done_valid),  64'(0));
        chk("rst_busy", 64'(busy),        64'(0));
        chk("rst_idx",  64'(rnd_idx),     64'(0));
        chk("rst_key",  64'(rnd_key),     64'(0));
        rst = 1'b0;
        tick();

        // Encrypt; inputs scrambled right after accept must not matter
        round_keys_i = bundle_a; encrypt_decrypt = 1'b0; done_ready = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0; round_keys_i = bundle_b; encrypt_decrypt = 1'b1;
        run_rounds("enc", 1'b0, 8'hA0);
        tick();
        chk("enc_idle_sr", 64'(start_ready), 64'(1));
        chk("enc_idle_dv", 64'(done_valid),  64'(0));
        chk("enc_idle_bs", 64'(busy),        64'(0));

        // Decrypt with 5 cycles of backpressure
        round_keys_i = bundle_a; encrypt_decrypt = 1'b1; done_ready = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0; encrypt_decrypt = 1'b0;
        run_rounds("dec", 1'b1, 8'hA0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_dv", 64'(done_valid),  64'(1));
            chk("bp_sr", 64'(start_ready), 64'(0));
            chk("bp_en", 64'(rnd_en),      64'(0));
            tick();
        end
        done_ready = 1'b1;
        tick();
        chk("bp_idle_sr", 64'(start_ready), 64'(1));
        chk("bp_idle_dv", 64'(done_valid),  64'(0));

        // Busy start at round 7 with bundle B / decrypt, held until accepted
        round_keys_i = bundle_a; encrypt_decrypt = 1'b0; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int k = 0; k < R; k++) begin
            if (k == 7) begin
                start_valid = 1'b1; round_keys_i = bundle_b; encrypt_decrypt = 1'b1;
            end
            chk("busy_key", 64'(rnd_key), 64'({8'hA0 + 8'(k), 40'h0}));
            chk("busy_sr",  64'(start_ready), 64'(0));
            tick();
        end
        chk("busy_done_dv", 64'(done_valid), 64'(1));
        tick();
        chk("busy_idle_sr", 64'(start_ready), 64'(1));
        tick();
        chk("busy_b_en",   64'(rnd_en),   64'(1));
        chk("busy_b_load", 64'(rnd_load), 64'(1));
        chk("busy_b_key",  64'(rnd_key),  64'({8'hBF, 40'h0}));
        start_valid = 1'b0;

        // Reset at round 9 of the B run
        for (int k = 1; k <= 9; k++) tick();
        chk("r9_idx", 64'(rnd_idx), 64'(9));
        chk("r9_key", 64'(rnd_key), 64'({8'hB6, 40'h0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r9_en",   64'(rnd_en),      64'(0));
        chk("r9_sr",   64'(start_ready), 64'(1));
        chk("r9_busy", 64'(busy),        64'(0));
        chk("r9_key0", 64'(rnd_key),     64'(0));
        for (int i = 0; i < 20; i++) begin
            chk("r9_no_dv", 64'(done_valid), 64'(0));
            tick();
        end
        round_keys_i = bundle_a; encrypt_decrypt = 1'b0; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        run_rounds("fresh", 1'b0, 8'hA0);
        tick();

        // Back-to-back: 16 rounds on, 2 cycles off
        start_valid = 1'b1; done_ready = 1'b1;
        tick();
        for (int i = 0; i < 54; i++) begin
            chk("b2b_en", 64'(rnd_en),      64'((i % 18) < 16));
            chk("b2b_dv", 64'(done_valid),  64'((i % 18) == 16));
            chk("b2b_sr", 64'(start_ready), 64'((i % 18) == 17));
            chk("b2b_ld", 64'(rnd_load),    64'((i % 18) == 0));
            tick();
        end
        start_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (!start_ready && n < 40) begin
                tick();
                n++;
            end
            chk("drain_timeout", 64'(start_ready), 64'(1));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
